// File: rtl/dti_apb_pkg.sv
// Shared APB completer types: bus phase enum, widths, address decode.
package dti_apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;

  typedef struct packed {
    logic [29:0] idx;
    logic        wr;
    logic        is_cnt;
    logic        err;
  } apb_dec_t;

  function automatic apb_dec_t apb_decode(
    input logic [APB_AW-1:0] addr,
    input logic [APB_AW-1:0] base,
    input int                nregs,
    input logic              wr
  );
    apb_dec_t          d;
    logic [APB_AW-1:0] off;
    off      = addr - base;
    d.idx    = off[31:2];
    d.wr     = wr;
    d.is_cnt = (d.idx == 30'(nregs));
    d.err    = (addr[1:0] != 2'b00)
             || (d.idx > 30'(nregs))
             || (wr && d.is_cnt);
    return d;
  endfunction

endpackage

// File: rtl/dti_apb_slv_regbank.sv
// RW register array behind the APB completer: per-index write,
// read mux and one-cycle write pulses.
import dti_apb_pkg::*;

module dti_apb_slv_regbank #(
  parameter int NUM_REGS = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [29:0]                widx_i,
  input  logic [APB_DW-1:0]          wdata_i,
  input  logic [29:0]                ridx_i,
  output logic [APB_DW-1:0]          rdata_o,
  output logic [NUM_REGS*APB_DW-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  logic [APB_DW-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;
  logic [NUM_REGS-1:0] we_d;

  always_comb begin
    we_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      we_d[i] = we_i && (widx_i == 30'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pulse_q <= we_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_d[i]) regs_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx_i == 30'(i)) rdata_o = regs_q[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*APB_DW +: APB_DW] = regs_q[g];
  end

  assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/dti_apb_reg_slave.sv
// APB3 register completer: RW window, RO transfer counter, PSLVERR.
// Wait states enabled by defining DTI_APB_SLV_WAIT_EN.
import dti_apb_pkg::*;

module dti_apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          NUM_REGS    = 4,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [APB_AW-1:0]          apb_paddr,
  input  logic                       apb_psel,
  input  logic                       apb_penable,
  input  logic                       apb_pwrite,
  input  logic [APB_DW-1:0]          apb_pwdata,
  output logic [APB_DW-1:0]          apb_prdata,
  output logic                       apb_pready,
  output logic                       apb_pslverr,
  output logic [NUM_REGS*APB_DW-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  apb_state_e        state_q;
  apb_state_e        phase;
  apb_dec_t          dec_c;
  apb_dec_t          dec_q;
  apb_dec_t          dec_s;
  logic [APB_DW-1:0] wdata_q;
  logic [31:0]       cnt_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [APB_DW-1:0] prdata_q;
  logic [APB_DW-1:0] rb_rdata;
  logic [APB_DW-1:0] rd_val;
  logic              setup_hit;
  logic              done;
  logic              rb_we;
`ifdef DTI_APB_SLV_WAIT_EN
  logic [15:0]       wait_q;
`endif

  assign dec_c = apb_decode(apb_paddr, BASE_ADDR,
                            NUM_REGS, apb_pwrite);

  // penable alone in IDLE never opens a transfer
  assign setup_hit = (state_q == APB_IDLE)
                   && apb_psel && !apb_penable;
  assign phase = setup_hit ? APB_SETUP : state_q;
  assign done  = (state_q == APB_ACCESS) && apb_psel
               && apb_penable && pready_q;

  assign dec_s  = setup_hit ? dec_c : dec_q;
  assign rd_val = dec_s.err    ? '0    :
                  dec_s.is_cnt ? cnt_q : rb_rdata;
  assign rb_we  = done && dec_q.wr && !dec_q.err;

  dti_apb_slv_regbank #(
    .NUM_REGS (NUM_REGS)
  ) u_regbank (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .we_i       (rb_we),
    .widx_i     (dec_q.idx),
    .wdata_i    (wdata_q),
    .ridx_i     (dec_s.idx),
    .rdata_o    (rb_rdata),
    .regs_o     (reg_q),
    .wr_pulse_o (reg_wr_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= APB_IDLE;
      dec_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef DTI_APB_SLV_WAIT_EN
      wait_q    <= '0;
`endif
    end else begin
      unique case (phase)
        APB_SETUP: begin
          state_q <= APB_ACCESS;
          dec_q   <= dec_c;
          wdata_q <= apb_pwdata;
`ifdef DTI_APB_SLV_WAIT_EN
          wait_q  <= 16'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            pready_q  <= 1'b1;
            pslverr_q <= dec_c.err;
            prdata_q  <= rd_val;
          end
`else
          pready_q  <= 1'b1;
          pslverr_q <= dec_c.err;
          prdata_q  <= rd_val;
`endif
        end
        APB_ACCESS: begin
          if (!apb_psel) begin
            state_q   <= APB_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end else if (pready_q) begin
            if (done) begin
              state_q   <= APB_IDLE;
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              prdata_q  <= '0;
              if (!dec_q.err) cnt_q <= cnt_q + 32'd1;
            end
          end
`ifdef DTI_APB_SLV_WAIT_EN
          else begin
            wait_q <= wait_q - 16'd1;
            if (wait_q <= 16'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= dec_q.err;
              prdata_q  <= rd_val;
            end
          end
`endif
        end
        default: state_q <= APB_IDLE;
      endcase
    end
  end

  assign apb_prdata  = prdata_q;
  assign apb_pready  = pready_q;
  assign apb_pslverr = pslverr_q;

endmodule

// File: tb/tb_dti_apb_reg_slave.sv
// Directed bench for dti_apb_reg_slave: register access, errors,
// back-to-back, optional wait states, reset abort.
module tb_dti_apb_reg_slave;

`ifdef DTI_APB_SLV_WAIT_EN
  localparam int EW = 2;
`else
  localparam int EW = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  paddr;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic [127:0] regs;
  logic [3:0]   pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dti_apb_reg_slave #(
    .BASE_ADDR   (32'h0000_0100),
    .NUM_REGS    (4),
    .WAIT_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .apb_paddr    (paddr),
    .apb_psel     (psel),
    .apb_penable  (penable),
    .apb_pwrite   (pwrite),
    .apb_pwdata   (pwdata),
    .apb_prdata   (prdata),
    .apb_pready   (pready),
    .apb_pslverr  (pslverr),
    .reg_q        (regs),
    .reg_wr_pulse (pulse)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Leaves psel high so a following call runs back-to-back
  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic alt,
                      output logic [31:0] rd, output logic er,
                      output int nw, output logic [3:0] pl);
    logic got;
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = a;
    pwrite  = w;
    pwdata  = wd;
    @(posedge clk);
    #1;
    penable = 1'b1;
    if (alt) begin
      pwdata = ~wd;
      paddr  = 32'h114;
      pwrite = ~w;
    end
    nw  = 0;
    rd  = '0;
    er  = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pready) begin
        rd  = prdata;
        er  = pslverr;
        got = 1'b1;
        break;
      end
      nw++;
    end
    chk("ready_seen", got, 1);
    @(posedge clk);
    #1;
    pl      = pulse;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          nw;
  logic [3:0]  pl;
  int          nw2;

  initial begin
    reset_n = 1'b0;
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h100;
    pwdata  = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_regs", regs, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();

    // write then read register 0
    xfer(32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0, rd, er, nw, pl);
    chk("w0_err", er, 0);
    chk("w0_wait", nw, EW);
    chk("w0_pulse", pl, 4'b0001);
    chk("w0_reg", regs, 128'hDEAD_BEEF);
    idle();
    chk("w0_pulse_one", pulse, 0);
    xfer(32'h100, 1'b0, 32'h0, 1'b0, rd, er, nw, pl);
    chk("r0_data", rd, 32'hDEAD_BEEF);
    chk("r0_err", er, 0);
    chk("r0_wait", nw, EW);
    idle();
    xfer(32'h110, 1'b0, 32'h0, 1'b0, rd, er, nw, pl);
    chk("cnt_2", rd, 2);
    idle();

    // error responses
    xfer(32'h102, 1'b0, 32'h0, 1'b0, rd, er, nw, pl);
    chk("mis_err", er, 1);
    chk("mis_data", rd, 0);
    idle();
    xfer(32'h114, 1'b0, 32'h0, 1'b0, rd, er, nw, pl);
    chk("oor_err", er, 1);
    chk("oor_data", rd, 0);
    idle();
    xfer(32'h110, 1'b1, 32'h1234, 1'b0, rd, er, nw, pl);
    chk("ro_err", er, 1);
    chk("ro_pulse", pl, 0);
    idle();
    chk("err_regs", regs, 128'hDEAD_BEEF);
    xfer(32'h110, 1'b0, 32'h0, 1'b0, rd, er, nw, pl);
    chk("cnt_3", rd, 3);
    idle();

    // back-to-back writes, psel held high
    xfer(32'h104, 1'b1, 32'h1, 1'b0, rd, er, nw, pl);
    xfer(32'h108, 1'b1, 32'h2, 1'b0, rd, er, nw2, pl);
    chk("b2b_wait1", nw, EW);
    chk("b2b_wait2", nw2, EW);
    chk("b2b_pulse", pl, 4'b0100);
    chk("b2b_regs", regs,
        {32'h0, 32'h2, 32'h1, 32'hDEAD_BEEF});
    idle();

    // bus changes during ACCESS are ignored
    xfer(32'h10C, 1'b1, 32'h1234_5678, 1'b1, rd, er, nw, pl);
    chk("alt_err", er, 0);
    chk("alt_wait", nw, EW);
    chk("alt_pulse", pl, 4'b1000);
    chk("alt_reg3", regs[127:96], 32'h1234_5678);
    idle();
    xfer(32'h110, 1'b0, 32'h0, 1'b0, rd, er, nw, pl);
    chk("cnt_7", rd, 7);
    idle();

    // reset aborts a write in ACCESS
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h10C;
    pwdata  = 32'h55;
    @(posedge clk);
    #1;
    penable = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_pready", pready, 0);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_regs", regs, 0);
    chk("abort_pulse", pulse, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();

    // penable without setup is ignored
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("noset_pready", pready, 0);
    @(posedge clk);
    #1;
    idle();

    xfer(32'h10C, 1'b0, 32'h0, 1'b0, rd, er, nw, pl);
    chk("post_reg3", rd, 0);
    chk("post_err", er, 0);
    idle();
    xfer(32'h110, 1'b0, 32'h0, 1'b0, rd, er, nw, pl);
    chk("post_cnt", rd, 1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
